// File: rtl/serial_pkg.sv
// serial_pkg
// Shared definitions for the console serial receive/transmit paths:
// oversampling constants, character width and the receiver FSM encoding.
//
// Optional feature macro: RX_PARITY_EN adds the PARITY state (8E1 frames).
package serial_pkg;

    localparam int OVERSAMPLE = 16;   // ticks per bit period
    localparam int MID_SAMPLE = 8;    // tick at which the start bit is centred
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef RX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } rx_state_t;

endpackage

// File: rtl/baud_tick.sv
// baud_tick
// Oversample tick divider: counts 0..BAUD_DIV-1 and pulses tick for one
// clock on the wrap.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   clear    synchronous restart of the count (no tick in that cycle)
//   tick     one-clock pulse every BAUD_DIV clocks
module baud_tick #(
    parameter int BAUD_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign tick = !clear && (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/kbd_rx.sv
// kbd_rx
// Console keyboard serial receiver (KL8E-style). Deserialises the async rx
// line with 16x oversampling and presents each character with a flag that
// the instruction decode clears on read.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   rx          asynchronous serial input, idles high
//   clr_flag    one-cycle clear of flag and status bits
//   char[0:7]   last character; char[7] is the LSB (first data bit on line)
//   flag        character available
//   frame_err   stop bit of last character sampled 0
//   overrun     a character was loaded while flag was still set
//   parity_err  even-parity mismatch (0 unless RX_PARITY_EN)
//   state_dbg   current FSM state encoding (serial_pkg::rx_state_t)
//
// Handshake: flag rises on the clock after the stop-bit sample; it stays
// set until clr_flag is seen. A load in the same cycle as clr_flag wins,
// leaving flag=1 and overrun=0.
//
// Optional feature macro: RX_PARITY_EN (start + 8 data + even parity + stop).
module kbd_rx
    import serial_pkg::*;
#(
    parameter int BAUD_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       clr_flag,
    output logic [0:7] char,
    output logic       flag,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic [2:0] state_dbg
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    rx_state_t  state_q, state_d;
    logic [3:0] samp_cnt_q, samp_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       stop_bit_q, stop_bit_d;
    logic       load_pend_q, load_pend_d;
    logic [0:7] char_q, char_d;
    logic       flag_q, flag_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic       parity_err_q, parity_err_d;
`ifdef RX_PARITY_EN
    logic       par_bit_q, par_bit_d;
`endif

    logic rx_s;
    logic tick;
    logic div_clear;
    logic parity_mismatch;

    assign rx_s = sync2_q;

`ifdef RX_PARITY_EN
    assign parity_mismatch = (^shift_q) ^ par_bit_q;
`else
    assign parity_mismatch = 1'b0;
`endif

    baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (div_clear),
        .tick    (tick)
    );

    always_comb begin
        sync1_d      = rx;
        sync2_d      = sync1_q;
        state_d      = state_q;
        samp_cnt_d   = samp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        stop_bit_d   = stop_bit_q;
        load_pend_d  = load_pend_q;
        char_d       = char_q;
        flag_d       = flag_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        parity_err_d = parity_err_q;
        div_clear    = 1'b0;
`ifdef RX_PARITY_EN
        par_bit_d    = par_bit_q;
`endif

        if (clr_flag) begin
            flag_d       = 1'b0;
            frame_err_d  = 1'b0;
            overrun_d    = 1'b0;
            parity_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    div_clear  = 1'b1;
                    samp_cnt_d = '0;
                end
            end

            START: begin
                if (tick) begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == 4'(MID_SAMPLE - 1)) begin
                        if (rx_s) begin
                            // False start: line went back high before mid-bit.
                            state_d = IDLE;
                        end else begin
                            samp_cnt_d = '0;
                            bit_cnt_d  = '0;
                            state_d    = DATA;
                        end
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    // Counter wraps 15 -> 0, so each bit is sampled 16 ticks
                    // after the previous mid-bit point.
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == 4'(OVERSAMPLE - 1)) begin
                        shift_d   = {rx_s, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
            end

`ifdef RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == 4'(OVERSAMPLE - 1)) begin
                        par_bit_d = rx_s;
                        state_d   = STOP;
                    end
                end
            end
`endif

            STOP: begin
                if (load_pend_q) begin
                    // Load cycle: overrides any coincident clr_flag.
                    char_d       = shift_q;
                    flag_d       = 1'b1;
                    frame_err_d  = ~stop_bit_q;
                    parity_err_d = parity_mismatch;
                    overrun_d    = flag_q & ~clr_flag;
                    load_pend_d  = 1'b0;
                    state_d      = IDLE;
                end else if (tick) begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == 4'(OVERSAMPLE - 1)) begin
                        stop_bit_d  = rx_s;
                        load_pend_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= IDLE;
            samp_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            stop_bit_q   <= 1'b1;
            load_pend_q  <= 1'b0;
            char_q       <= '0;
            flag_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef RX_PARITY_EN
            par_bit_q    <= 1'b0;
`endif
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            stop_bit_q   <= stop_bit_d;
            load_pend_q  <= load_pend_d;
            char_q       <= char_d;
            flag_q       <= flag_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
`ifdef RX_PARITY_EN
            par_bit_q    <= par_bit_d;
`endif
        end
    end

    assign char       = char_q;
    assign flag       = flag_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign parity_err = parity_err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_kbd_rx.sv
// tb_kbd_rx
// Self-checking bench for kbd_rx. A frame driver pushes the expected load
// (cycle, char, status bits) into exp_q; a monitor pops and compares when
// the receiver leaves STOP for IDLE.
module tb_kbd_rx;
    import serial_pkg::*;

    localparam int BAUD_DIV = 2;
    localparam int BIT_CLKS = OVERSAMPLE * BAUD_DIV;
`ifdef RX_PARITY_EN
    localparam int STOP_M   = 168;
    localparam bit PAR      = 1'b1;
`else
    localparam int STOP_M   = 152;
    localparam bit PAR      = 1'b0;
`endif
    localparam int LOAD_LAT = 3 + BAUD_DIV * STOP_M;

    // ---------------- clock / reset ----------------
    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       rx       = 1'b1;
    logic       clr_flag = 1'b0;
    logic [0:7] char;
    logic       flag;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // {load_cycle[31:0], overrun, parity_err, frame_err, char[7:0]}
    logic [42:0] exp_q[$];
    logic [42:0] mon_e;
    logic [2:0]  prev_state = 3'(IDLE);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    kbd_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .clr_flag   (clr_flag),
        .char       (char),
        .flag       (flag),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .state_dbg  (state_dbg)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset_n && prev_state == 3'(STOP) && state_dbg == 3'(IDLE)) begin
            chk("load_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("load_cycle", 64'(cyc), 64'(mon_e[42:11]));
                chk("char",       64'(char), 64'(mon_e[7:0]));
                chk("flag",       64'(flag), 64'(1));
                chk("frame_err",  64'(frame_err), 64'(mon_e[8]));
                chk("parity_err", 64'(parity_err), 64'(mon_e[9]));
                chk("overrun",    64'(overrun), 64'(mon_e[10]));
            end
        end
        prev_state <= state_dbg;
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input logic par_bad, input logic exp_ov);
        int   k;
        logic pe_exp;
        @(negedge clk);
        rx     = 1'b0;
        k      = cyc + 1;   // edge at which the first sync flop captures 0
        pe_exp = PAR ? par_bad : 1'b0;
        exp_q.push_back({32'(k + LOAD_LAT), exp_ov, pe_exp, ~stop_val, data});
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
`ifdef RX_PARITY_EN
        rx = (^data) ^ par_bad;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        rx = stop_val;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_flag = 1'b1;
        @(negedge clk);
        clr_flag = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_char"},       64'(char), 64'(0));
        chk({tag, "_flag"},       64'(flag), 64'(0));
        chk({tag, "_frame_err"},  64'(frame_err), 64'(0));
        chk({tag, "_overrun"},    64'(overrun), 64'(0));
        chk({tag, "_parity_err"}, 64'(parity_err), 64'(0));
        chk({tag, "_state"},      64'(state_dbg), 64'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] part;

        // Reset held with rx toggling.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rx = 1'($urandom_range(0, 1));
        end
        check_all_zero("reset");
        @(negedge clk);
        rx      = 1'b1;
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_flag", 64'(flag), 64'(0));

        // Normal character, then clear.
        send_frame(8'o101, 1'b1, 1'b0, 1'b0);
        pulse_clr();
        chk("clr_flag",    64'(flag), 64'(0));
        chk("clr_char",    64'(char), 64'(8'o101));
        chk("clr_overrun", 64'(overrun), 64'(0));

        // Glitch shorter than half a bit.
        @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_flag",  64'(flag), 64'(0));
        chk("glitch_state", 64'(state_dbg), 64'(IDLE));
        send_frame(8'o252, 1'b1, 1'b0, 1'b0);
        pulse_clr();

        // Framing error: stop bit driven low.
        send_frame(8'o252, 1'b0, 1'b0, 1'b0);
        pulse_clr();
        chk("fe_cleared", 64'(frame_err), 64'(0));

        // Overrun: two characters without clearing.
        send_frame(8'h5a, 1'b1, 1'b0, 1'b0);
        send_frame(8'hc3, 1'b1, 1'b0, 1'b1);

        // clr_flag coincident with the load edge: load wins.
        fork
            send_frame(8'h3c, 1'b1, 1'b0, 1'b0);
            begin
                @(negedge clk);
                repeat (LOAD_LAT) @(negedge clk);
                clr_flag = 1'b1;
                @(negedge clk);
                clr_flag = 1'b0;
            end
        join

        // Reset in the middle of data bit 3.
        part = 8'he7;
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = part[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = part[3];
        repeat (BIT_CLKS / 2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        send_frame(8'h96, 1'b1, 1'b0, 1'b0);

`ifdef RX_PARITY_EN
        pulse_clr();
        send_frame(8'h96, 1'b1, 1'b1, 1'b0);
`endif

        repeat (50) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
